traffic_phase_arbiter: RTL and testbench
========================================

// Module: traffic_phase_arbiter
// PURPOSE
//  Demand-driven phase scheduler for a 4-way intersection (N,S,W,E), one green approach at a time.
//  Arbitrates vehicle requests round-robin, enforces min/max green, yellow and all-red clearance.
//  Supports emergency-vehicle preemption.
//  Drives the per-approach lamp buses: 001=green, 010=yellow, 100=red.
// PARAMETERS
//  CNT_W     8   width of phase timer (ticks)
//  GREEN_MIN 4   min green ticks before gap-out allowed (>=1)
//  GREEN_MAX 16  max green ticks while others wait (>=GREEN_MIN)
//  YELLOW_T  3   yellow duration, ticks (>=1)
//  ALLRED_T  1   all-red clearance, ticks (>=1); all values < 2**CNT_W
// PORTS
//  clk          in   1  clock
//  rst          in   1  reset, asynchronous, active-high
//  tick         in   1  1-clk timing strobe; timer advances only when tick=1
//  req          in   4  vehicle present, level; bit0=N,1=S,2=W,3=E
//  emg_valid    in   1  emergency preemption request, level
//  emg_dir      in   2  emergency direction (0=N,1=S,2=W,3=E)
//  emg_ack      out  1  emergency direction is currently green
//  N,S,W,E      out  3  lamp codes per approach
//  phase        out  2  0=RED_HOLD,1=GREEN,2=YELLOW,3=ALLRED
//  phase_dir    out  2  direction owning current GREEN/YELLOW (last owner in ALLRED/RED_HOLD)
// BEHAVIOUR
//  - Reset: phase=RED_HOLD, phase_dir=0, ptr=0, tmr=0, N=S=W=E=100, emg_ack=0.
//    Async assert mid-operation forces this immediately.
//  - Outputs are pure decode of registered state; no input->output comb path.
//  - tmr = completed ticks in current phase; cleared on every phase entry.
//    Increments on tick, saturates at 2**CNT_W-1. Transitions are evaluated every clk.
//  - other_req = |(req & ~onehot(phase_dir)).
//  - Selection (sel): emg_valid ? emg_dir : first set req bit in order ptr+1, ptr+2, ptr+3, ptr (mod 4).
//  - RED_HOLD: if emg_valid or |req -> GREEN, phase_dir=sel, ptr=sel, next clk. Otherwise stay.
//  - GREEN: phase_dir lamp=001, others 100.
//    * emg_valid & emg_dir==phase_dir: hold, emg_ack=1, normal exits suppressed.
//    * emg_valid & emg_dir!=phase_dir: -> YELLOW next clk, ignoring GREEN_MIN.
//    * else -> YELLOW when other_req & (tmr>=GREEN_MAX | (tmr>=GREEN_MIN & !req[phase_dir])).
//    * no other_req: rest in green indefinitely, even if own req drops.
//  - YELLOW: phase_dir lamp=010, others 100. -> ALLRED when tmr==YELLOW_T.
//    Emergency does not abort yellow.
//  - ALLRED: all 100. When tmr==ALLRED_T:
//    if emg_valid or |req -> GREEN with sel (same direction allowed if it is the only requester);
//    else -> RED_HOLD.
//  - emg_ack=1 only in GREEN with emg_valid & emg_dir==phase_dir; emg_dir change mid-green = new preemption.
//  - tick and a transition on the same clk: the transition wins; tmr clears, that tick is not counted.
// STRUCTURE
//  - traffic_pkg: LT_GREEN/LT_YELLOW/LT_RED codes, DIR_N/S/W/E, phase encodings.
//  - Sub-module rr_pick4: comb round-robin picker (req[3:0], ptr[1:0] -> sel[1:0], any).
//  - Top holds the FSM, timer, ptr and lamp decode.
// TESTING (defaults, tick every 4 clks)
//  1 rst, req=0 for 200 clks -> phase=0, all lamps 100, emg_ack=0 throughout.
//  2 req=0001 -> next clk phase=1, N=001, S=W=E=100; held 500 clks, no other req.
//  3 N green, req=0011 held -> N=010 at tmr=16; 3 ticks yellow; 1 tick all-red; then S=001, phase_dir=1.
//  4 N green, req[N] drops at tmr=2, req[W]=1 -> yellow when tmr=4; next green W.
//  5 req=1111 held -> grant order N,S,W,E,N; each green exactly 16 ticks.
//  6 N green tmr=1, emg E -> N=010 next clk; after clearance E=001, emg_ack=1, held while emg_valid
//    despite req=1111; rst mid-yellow -> all 100 same cycle.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection phase arbiter: lamp codes,
// approach indices, phase numbers and a small direction helper.
package traffic_pkg;

    // Lamp bus codes, one-hot so a stuck or doubled lamp is easy to spot.
    localparam logic [2:0] LT_GREEN  = 3'b001;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_RED    = 3'b100;

    // Approach indices; also the bit positions in the req vector.
    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_S = 2'd1;
    localparam logic [1:0] DIR_W = 2'd2;
    localparam logic [1:0] DIR_E = 2'd3;

    // Phase encodings, exported unchanged on the phase output.
    localparam logic [1:0] PH_RED_HOLD = 2'd0;
    localparam logic [1:0] PH_GREEN    = 2'd1;
    localparam logic [1:0] PH_YELLOW   = 2'd2;
    localparam logic [1:0] PH_ALLRED   = 2'd3;

    // One-hot mask for an approach, used to split own vs. other demand.
    function automatic logic [3:0] dir_onehot(input logic [1:0] dir);
        return 4'b0001 << dir;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker over four requesters. Search starts
// just after ptr and wraps, so ptr itself is the lowest priority and is
// only chosen when it is the sole requester.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] sel,
    output logic       any
);

    logic       found;
    logic [1:0] cand;

    // Walk ptr+1, ptr+2, ptr+3, ptr and keep the first set request.
    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        sel   = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/traffic_phase_arbiter.sv
// Demand-driven phase scheduler for a four-way intersection. One approach
// is green at a time; service rotates round-robin with min/max green,
// fixed yellow and all-red clearance, plus emergency preemption.
// All outputs decode registered state only.
module traffic_phase_arbiter
    import traffic_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 16,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] req,
    input  logic       emg_valid,
    input  logic [1:0] emg_dir,
    output logic       emg_ack,
    output logic [2:0] N,
    output logic [2:0] S,
    output logic [2:0] W,
    output logic [2:0] E,
    output logic [1:0] phase,
    output logic [1:0] phase_dir
);

    localparam logic [CNT_W-1:0] TMR_MAX     = '1;
    localparam logic [CNT_W-1:0] GREEN_MIN_C = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0] GREEN_MAX_C = CNT_W'(GREEN_MAX);
    localparam logic [CNT_W-1:0] YELLOW_C    = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] ALLRED_C    = CNT_W'(ALLRED_T);

    logic [1:0]       phase_q, phase_d;
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic             ack_q, ack_d;

    logic [1:0]       pick_sel;
    logic             pick_any;
    logic [1:0]       sel;
    logic             go;
    logic             own_req;
    logic             other_req;
    logic             green_expired;
    logic [3:0][2:0]  lamp;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_q),
        .sel (pick_sel),
        .any (pick_any)
    );

    // An emergency overrides normal demand for the next grant.
    assign sel = emg_valid ? emg_dir : pick_sel;
    assign go  = emg_valid | pick_any;

    // Demand split between the approach owning the phase and everyone else.
    assign own_req   = req[dir_q];
    assign other_req = |(req & ~dir_onehot(dir_q));

    // Normal green exit: forced at max green, or gap-out after min green.
    assign green_expired = (tmr_q >= GREEN_MAX_C) ||
                           ((tmr_q >= GREEN_MIN_C) && !own_req);

    // Phase sequencing, grant selection and phase timer.
    always_comb begin
        phase_d = phase_q;
        dir_d   = dir_q;
        ptr_d   = ptr_q;
        case (phase_q)
            PH_RED_HOLD: begin
                if (go) begin
                    phase_d = PH_GREEN;
                    dir_d   = sel;
                    ptr_d   = sel;
                end
            end
            PH_GREEN: begin
                if (emg_valid) begin
                    // Preemption for the current owner holds green; any
                    // other direction cuts green short regardless of min.
                    if (emg_dir != dir_q) begin
                        phase_d = PH_YELLOW;
                    end
                end else if (other_req && green_expired) begin
                    phase_d = PH_YELLOW;
                end
            end
            PH_YELLOW: begin
                // Yellow always runs to completion, even under preemption.
                if (tmr_q == YELLOW_C) begin
                    phase_d = PH_ALLRED;
                end
            end
            PH_ALLRED: begin
                if (tmr_q == ALLRED_C) begin
                    if (go) begin
                        phase_d = PH_GREEN;
                        dir_d   = sel;
                        ptr_d   = sel;
                    end else begin
                        phase_d = PH_RED_HOLD;
                    end
                end
            end
            default: phase_d = PH_RED_HOLD;
        endcase

        // The timer restarts on every phase entry; a tick landing on the
        // transition clock is deliberately dropped.
        if (phase_d != phase_q) begin
            tmr_d = '0;
        end else if (tick && (tmr_q != TMR_MAX)) begin
            tmr_d = tmr_q + CNT_W'(1);
        end else begin
            tmr_d = tmr_q;
        end

        // Acknowledge is registered alongside the phase it describes.
        ack_d = (phase_d == PH_GREEN) && emg_valid && (emg_dir == dir_d);
    end

    // State registers with asynchronous reset to all-red hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PH_RED_HOLD;
            dir_q   <= DIR_N;
            ptr_q   <= DIR_N;
            tmr_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            phase_q <= phase_d;
            dir_q   <= dir_d;
            ptr_q   <= ptr_d;
            tmr_q   <= tmr_d;
            ack_q   <= ack_d;
        end
    end

    // Lamp decode: everything red except the owner in green or yellow.
    always_comb begin
        lamp = {4{LT_RED}};
        if (phase_q == PH_GREEN) begin
            lamp[dir_q] = LT_GREEN;
        end else if (phase_q == PH_YELLOW) begin
            lamp[dir_q] = LT_YELLOW;
        end
    end

    assign N         = lamp[DIR_N];
    assign S         = lamp[DIR_S];
    assign W         = lamp[DIR_W];
    assign E         = lamp[DIR_E];
    assign phase     = phase_q;
    assign phase_dir = dir_q;
    assign emg_ack   = ack_q;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Self-checking bench for traffic_phase_arbiter: a per-clock scoreboard
// against a behavioural model, a table of phase-sequence vectors, and
// hand-written sequences for gap-out, preemption and async reset.
module tb_traffic_phase_arbiter;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] req;
    logic       emg_valid;
    logic [1:0] emg_dir;
    logic       emg_ack;
    logic [2:0] N, S, W, E;
    logic [1:0] phase, phase_dir;

    always #5 clk = ~clk;

    traffic_phase_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .req       (req),
        .emg_valid (emg_valid),
        .emg_dir   (emg_dir),
        .emg_ack   (emg_ack),
        .N         (N),
        .S         (S),
        .W         (W),
        .E         (E),
        .phase     (phase),
        .phase_dir (phase_dir)
    );

    typedef struct packed {
        logic [1:0] ph;
        logic [1:0] dir;
        logic       ack;
        logic [2:0] n, s, w, e;
    } obs_t;

    localparam obs_t RST_OBS = {2'd0, 2'd0, 1'b0, LT_RED, LT_RED, LT_RED, LT_RED};

    typedef struct {
        logic [3:0] req;
        logic       ev;
        logic [1:0] ed;
        logic [1:0] target;
        logic [1:0] exp_dir;
        int         exp_ticks;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ph_ticks = 0;
    int   last_ticks = 0;
    obs_t exp_q[$];

    // Reference model state
    logic [1:0] m_phase, m_dir, m_ptr;
    int         m_tmr;
    logic       m_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s (cyc %0d): got %0h expected %0h", name, cyc, act, want);
        end
    endtask

    function automatic obs_t dut_obs();
        return {phase, phase_dir, emg_ack, N, S, W, E};
    endfunction

    function automatic obs_t model_obs();
        logic [2:0] l [4];
        for (int d = 0; d < 4; d++) l[d] = LT_RED;
        if (m_phase == PH_GREEN)  l[m_dir] = LT_GREEN;
        if (m_phase == PH_YELLOW) l[m_dir] = LT_YELLOW;
        return {m_phase, m_dir, m_ack, l[0], l[1], l[2], l[3]};
    endfunction

    function automatic logic [1:0] model_pick(input logic [3:0] r, input logic [1:0] p);
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] d;
            d = 2'((int'(p) + k) % 4);
            if (r[d]) return d;
        end
        return p;
    endfunction

    task automatic model_reset();
        m_phase = PH_RED_HOLD;
        m_dir   = DIR_N;
        m_ptr   = DIR_N;
        m_tmr   = 0;
        m_ack   = 1'b0;
        exp_q.delete();
        ph_ticks   = 0;
        last_ticks = 0;
    endtask

    // One clock of the intended behaviour, using the default timing values.
    task automatic model_clock();
        logic [1:0] s, np, nd, nptr;
        logic       want_green, others;
        s          = emg_valid ? emg_dir : model_pick(req, m_ptr);
        want_green = emg_valid || (req != 4'b0);
        others     = (req & ~(4'b0001 << m_dir)) != 4'b0;
        np = m_phase; nd = m_dir; nptr = m_ptr;
        case (m_phase)
            PH_RED_HOLD: if (want_green) begin np = PH_GREEN; nd = s; nptr = s; end
            PH_GREEN: begin
                if (emg_valid) begin
                    if (emg_dir != m_dir) np = PH_YELLOW;
                end else if (others && (m_tmr >= 16 || (m_tmr >= 4 && !req[m_dir]))) begin
                    np = PH_YELLOW;
                end
            end
            PH_YELLOW: if (m_tmr == 3) np = PH_ALLRED;
            default: if (m_tmr == 1) begin
                if (want_green) begin np = PH_GREEN; nd = s; nptr = s; end
                else np = PH_RED_HOLD;
            end
        endcase
        if (np != m_phase) m_tmr = 0;
        else if (tick && m_tmr < 255) m_tmr++;
        m_phase = np; m_dir = nd; m_ptr = nptr;
        m_ack = (np == PH_GREEN) && emg_valid && (emg_dir == nd);
    endtask

    // Drive one clock: push the model's expectation, then compare after the edge.
    task automatic step();
        logic [1:0] prev_phase;
        obs_t want;
        tick = (cyc % 4 == 0);
        cyc++;
        prev_phase = phase;
        model_clock();
        exp_q.push_back(model_obs());
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check("cycle", 32'(dut_obs()), 32'(want));
        if (phase != prev_phase) begin
            last_ticks = ph_ticks;
            ph_ticks   = 0;
        end else if (tick) begin
            ph_ticks++;
        end
    endtask

    task automatic run_until(input string name, input logic [1:0] target, input int bound);
        logic [1:0] prev;
        for (int k = 0; k < bound; k++) begin
            prev = phase;
            step();
            if (phase == target && prev != target) return;
        end
        total++;
        bad++;
        $display("FAIL %s timeout: phase stuck at %0d, expected entry to %0d", name, phase, target);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0; emg_valid = 1'b0; emg_dir = 2'd0; tick = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(dut_obs()), 32'(RST_OBS));
        rst = 1'b0;
    endtask

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{4'b0011, 1'b0, 2'd0, PH_YELLOW, DIR_N, 16};
        tbl[1]  = '{4'b0011, 1'b0, 2'd0, PH_ALLRED, DIR_N, 3};
        tbl[2]  = '{4'b0011, 1'b0, 2'd0, PH_GREEN,  DIR_S, 1};
        tbl[3]  = '{4'b1111, 1'b0, 2'd0, PH_YELLOW, DIR_S, 16};
        tbl[4]  = '{4'b1111, 1'b0, 2'd0, PH_ALLRED, DIR_S, 3};
        tbl[5]  = '{4'b1111, 1'b0, 2'd0, PH_GREEN,  DIR_W, 1};
        tbl[6]  = '{4'b1111, 1'b0, 2'd0, PH_YELLOW, DIR_W, 16};
        tbl[7]  = '{4'b1111, 1'b0, 2'd0, PH_ALLRED, DIR_W, 3};
        tbl[8]  = '{4'b1111, 1'b0, 2'd0, PH_GREEN,  DIR_E, 1};
        tbl[9]  = '{4'b1111, 1'b0, 2'd0, PH_YELLOW, DIR_E, 16};
        tbl[10] = '{4'b1111, 1'b0, 2'd0, PH_ALLRED, DIR_E, 3};
        tbl[11] = '{4'b1111, 1'b0, 2'd0, PH_GREEN,  DIR_N, 1};
        tbl[12] = '{4'b1111, 1'b0, 2'd0, PH_YELLOW, DIR_N, 16};

        // Idle after reset: hold all-red, no acknowledge.
        do_reset();
        repeat (200) step();
        check("idle_phase", 32'(phase), 32'(PH_RED_HOLD));
        check("idle_lamps", 32'({N, S, W, E}), 32'({LT_RED, LT_RED, LT_RED, LT_RED}));

        // Single requester: green next clock and rests there indefinitely.
        req = 4'b0001;
        step();
        check("first_grant_phase", 32'(phase), 32'(PH_GREEN));
        check("first_grant_lamps", 32'({N, S, W, E}), 32'({LT_GREEN, LT_RED, LT_RED, LT_RED}));
        repeat (500) step();
        check("rest_phase", 32'(phase), 32'(PH_GREEN));
        check("rest_dir", 32'(phase_dir), 32'(DIR_N));

        // Max-green handover N->S, then full rotation with everyone waiting.
        do_reset();
        req = 4'b0001;
        step();
        for (int i = 0; i < 13; i++) begin
            req = tbl[i].req; emg_valid = tbl[i].ev; emg_dir = tbl[i].ed;
            run_until($sformatf("vec%0d", i), tbl[i].target, 200);
            check($sformatf("vec%0d_dir", i), 32'(phase_dir), 32'(tbl[i].exp_dir));
            check($sformatf("vec%0d_ticks", i), 32'(last_ticks), 32'(tbl[i].exp_ticks));
        end

        // Gap-out: own demand drops at tmr=2, W waits; yellow at min green.
        do_reset();
        req = 4'b0001;
        step();
        for (int k = 0; k < 40 && ph_ticks < 2; k++) step();
        req = 4'b0100;
        run_until("gapout_yellow", PH_YELLOW, 100);
        check("gapout_ticks", 32'(last_ticks), 32'(4));
        check("gapout_yellow_dir", 32'(phase_dir), 32'(DIR_N));
        run_until("gapout_next_green", PH_GREEN, 100);
        check("gapout_next_dir", 32'(phase_dir), 32'(DIR_W));

        // Preemption: E emergency cuts N green before min, then holds E.
        do_reset();
        req = 4'b0001;
        step();
        for (int k = 0; k < 20 && ph_ticks < 1; k++) step();
        emg_valid = 1'b1; emg_dir = DIR_E; req = 4'b1111;
        step();
        check("emg_cut_phase", 32'(phase), 32'(PH_YELLOW));
        check("emg_cut_lamp_n", 32'(N), 32'(LT_YELLOW));
        check("emg_cut_ack", 32'(emg_ack), 32'(0));
        run_until("emg_grant", PH_GREEN, 100);
        check("emg_grant_dir", 32'(phase_dir), 32'(DIR_E));
        check("emg_grant_ack", 32'(emg_ack), 32'(1));
        check("emg_grant_lamp_e", 32'(E), 32'(LT_GREEN));
        repeat (150) step();
        check("emg_hold_phase", 32'(phase), 32'(PH_GREEN));
        check("emg_hold_ack", 32'(emg_ack), 32'(1));

        // Emergency moves to S mid-green: treated as a new preemption.
        emg_dir = DIR_S;
        step();
        check("emg_move_phase", 32'(phase), 32'(PH_YELLOW));
        check("emg_move_ack", 32'(emg_ack), 32'(0));
        step();

        // Asynchronous reset in the middle of yellow, away from any edge.
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", 32'(dut_obs()), 32'(RST_OBS));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        emg_valid = 1'b0;
        req = 4'b0000;
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
